// File: rtl/multiword_add_sequencer_pkg.sv
// Shared definitions for the multi-word add/subtract sequencer.
package multiword_add_sequencer_pkg;

    localparam int DEF_NUMBITS = 16;
    localparam int DEF_WORDS   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/multiword_add_sequencer_adder.sv
// One-word ripple-carry adder shared by every word step of the sequencer.
module ripple_carry_adder #(
    parameter int NUMBITS = 16
) (
    input  logic [NUMBITS-1:0] i_a,
    input  logic [NUMBITS-1:0] i_b,
    input  logic               i_cin,
    output logic [NUMBITS-1:0] o_sum,
    output logic               o_cout
);

    logic [NUMBITS:0] w_c;

    // Bitwise full adders; the carry ripples from bit 0 upward.
    always_comb begin
        w_c    = '0;
        o_sum  = '0;
        w_c[0] = i_cin;
        for (int i = 0; i < NUMBITS; i++) begin
            o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
            w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
        end
    end

    assign o_cout = w_c[NUMBITS];

endmodule

// File: rtl/multiword_add_sequencer.sv
// Wide add/subtract done one word per cycle, LSW first, over a single
// NUMBITS-wide adder with the carry held in a register between words.
module multiword_add_sequencer
    import multiword_add_sequencer_pkg::*;
#(
    parameter int NUMBITS = DEF_NUMBITS,
    parameter int WORDS   = DEF_WORDS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUMBITS*WORDS-1:0] a,
    input  logic [NUMBITS*WORDS-1:0] b,
    input  logic                     carryin,
    input  logic                     sub,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUMBITS*WORDS-1:0] sum,
    output logic                     carryout,
    output logic                     busy
);

    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

    seq_state_t r_state, w_state_nxt;

    logic [WORDS-1:0][NUMBITS-1:0] r_a, r_b, r_sum;
    logic [IDXW-1:0]               r_idx;
    logic                          r_carry;
    logic                          r_sub;
    logic                          r_carryout;

    logic [NUMBITS-1:0] w_b_word;
    logic [NUMBITS-1:0] w_sum_word;
    logic               w_cout;
    logic               w_last;

    // Subtraction is A + ~B + 1; the +1 comes from the preset carry.
    assign w_b_word = r_sub ? ~r_b[r_idx] : r_b[r_idx];
    assign w_last   = (r_idx == LAST_IDX);

    ripple_carry_adder #(.NUMBITS(NUMBITS)) u_adder (
        .i_a    (r_a[r_idx]),
        .i_b    (w_b_word),
        .i_cin  (r_carry),
        .o_sum  (w_sum_word),
        .o_cout (w_cout)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic and handshake outputs, all decoded from state.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        unique case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_last) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                busy        = 1'b0;
            end
        endcase
    end

    // Operand capture, per-word result write-back and carry chaining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a        <= '0;
            r_b        <= '0;
            r_sub      <= 1'b0;
            r_idx      <= '0;
            r_carry    <= 1'b0;
            r_sum      <= '0;
            r_carryout <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && in_valid) begin
                r_a     <= a;
                r_b     <= b;
                r_sub   <= sub;
                r_carry <= sub ? 1'b1 : carryin;
                r_idx   <= '0;
            end else if (r_state == ST_RUN) begin
                r_sum[r_idx] <= w_sum_word;
                r_carry      <= w_cout;
                if (w_last) r_carryout <= w_cout;
                else        r_idx      <= r_idx + IDXW'(1);
            end
        end
    end

    assign sum      = r_sum;
    assign carryout = r_carryout;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed-vector bench for multiword_add_sequencer (WORDS=4 and WORDS=1 builds).
module tb_multiword_add_sequencer;

    localparam int NB = 16;
    localparam int WD = 4;
    localparam int W  = NB * WD;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, carryin, sub, out_valid, out_ready, carryout, busy;
    logic [W-1:0]  a, b, sum;

    logic          u1_in_valid, u1_in_ready, u1_out_valid, u1_out_ready, u1_carryout, u1_busy;
    logic [NB-1:0] u1_a, u1_b, u1_sum;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multiword_add_sequencer #(.NUMBITS(NB), .WORDS(WD)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .carryin(carryin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .carryout(carryout), .busy(busy)
    );

    multiword_add_sequencer #(.NUMBITS(NB), .WORDS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(u1_in_valid), .in_ready(u1_in_ready),
        .a(u1_a), .b(u1_b), .carryin(1'b1), .sub(1'b0), .out_valid(u1_out_valid),
        .out_ready(u1_out_ready), .sum(u1_sum), .carryout(u1_carryout), .busy(u1_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present a request, let it be accepted, and wait for out_valid.
    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                            input logic tcin, input logic tsub, input string tag);
        int cyc;
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        a = ta; b = tb_; carryin = tcin; sub = tsub; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'(WD));
    endtask

    task automatic pop(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_ov_after_pop"}, 64'(out_valid), 64'd0);
        chk({tag, "_idle_after_pop"}, 64'(in_ready), 64'd1);
    endtask

    logic [W-1:0] s_sum;
    logic         s_co;

    logic [W-1:0] bb_a [3];
    logic [W-1:0] bb_b [3];
    logic         bb_c [3];
    logic         bb_s [3];
    logic [W-1:0] bb_es[3];
    logic         bb_ec[3];
    int           acc_cyc[3];

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; carryin = 1'b0; sub = 1'b0;
        u1_in_valid = 1'b0; u1_out_ready = 1'b0; u1_a = '0; u1_b = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rst_sum", sum, 64'd0);
        chk("rst_co", 64'(carryout), 64'd0);
        chk("rst_ov", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Carry ripples through every word.
        start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, "ripple");
        chk("ripple_sum", sum, 64'd0);
        chk("ripple_co", 64'(carryout), 64'd1);
        chk("ripple_busy", 64'(busy), 64'd1);
        pop("ripple");

        // Borrow across a word boundary, then a full-width borrow.
        start_op(64'h0000_0000_0001_0000, 64'd1, 1'b0, 1'b1, "borrow1");
        chk("borrow1_sum", sum, 64'h0000_0000_0000_FFFF);
        chk("borrow1_co", 64'(carryout), 64'd1);
        pop("borrow1");
        start_op(64'd0, 64'd1, 1'b1, 1'b1, "borrow2");
        chk("borrow2_sum", sum, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("borrow2_co", 64'(carryout), 64'd0);
        pop("borrow2");

        // Backpressure: result must hold while a new request waits.
        start_op(64'h0001_0002_0003_0004, 64'h0010_0020_0030_FFFF, 1'b1, 1'b0, "bp");
        s_sum = sum; s_co = carryout;
        chk("bp_sum", s_sum, 64'h0011_0022_0034_0004);
        chk("bp_co", 64'(s_co), 64'd0);
        a = 64'd100; b = 64'd23; carryin = 1'b0; sub = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_sum", sum, s_sum);
            chk("bp_hold_co", 64'(carryout), 64'(s_co));
            chk("bp_hold_in_ready", 64'(in_ready), 64'd0);
            chk("bp_hold_ov", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release_ov", 64'(out_valid), 64'd0);
        chk("bp_release_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;             // pending request accepted here
        in_valid = 1'b0;
        chk("bp_accept_busy", 64'(busy), 64'd1);
        begin
            int cyc;
            cyc = 0;
            while (!out_valid && cyc < 20) begin
                @(posedge clk); #1;
                cyc++;
            end
            chk("bp_new_latency", 64'(cyc), 64'(WD));
        end
        chk("bp_new_sum", sum, 64'd77);
        chk("bp_new_co", 64'(carryout), 64'd1);
        pop("bp_new");

        // Reset two RUN cycles into an operation.
        a = 64'hFFFF; b = 64'hFFFF; carryin = 1'b1; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_ov", 64'(out_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_sum", sum, 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        #1;
        start_op(64'd5, 64'd7, 1'b1, 1'b0, "post_rst");
        chk("post_rst_sum", sum, 64'd13);
        chk("post_rst_co", 64'(carryout), 64'd0);
        pop("post_rst");

        // Back-to-back with both handshakes held high.
        bb_a[0] = 64'h1234;                bb_b[0] = 64'h1111;                bb_c[0] = 1'b0; bb_s[0] = 1'b0;
        bb_es[0] = 64'h2345;               bb_ec[0] = 1'b0;
        bb_a[1] = 64'h0000_0001_0000_0000; bb_b[1] = 64'd1;                   bb_c[1] = 1'b0; bb_s[1] = 1'b1;
        bb_es[1] = 64'h0000_0000_FFFF_FFFF; bb_ec[1] = 1'b1;
        bb_a[2] = 64'hFFFF_0000_FFFF_0000; bb_b[2] = 64'h0001_0000_0001_0000; bb_c[2] = 1'b1; bb_s[2] = 1'b0;
        bb_es[2] = 64'h0000_0001_0000_0001; bb_ec[2] = 1'b1;
        begin
            int cyc, nacc, nres;
            logic do_acc, do_out;
            cyc = 0; nacc = 0; nres = 0;
            a = bb_a[0]; b = bb_b[0]; carryin = bb_c[0]; sub = bb_s[0];
            in_valid = 1'b1; out_ready = 1'b1;
            while (nres < 3 && cyc < 60) begin
                do_acc = in_ready && in_valid;
                do_out = out_valid;
                if (do_out) begin
                    chk("b2b_sum", sum, bb_es[nres]);
                    chk("b2b_co", 64'(carryout), 64'(bb_ec[nres]));
                    nres++;
                end
                @(posedge clk); #1;
                cyc++;
                if (do_acc) begin
                    acc_cyc[nacc] = cyc;
                    nacc++;
                    if (nacc < 3) begin
                        a = bb_a[nacc]; b = bb_b[nacc]; carryin = bb_c[nacc]; sub = bb_s[nacc];
                    end else begin
                        in_valid = 1'b0;
                    end
                end
            end
            out_ready = 1'b0;
            in_valid  = 1'b0;
            chk("b2b_results", 64'(nres), 64'd3);
            chk("b2b_accepts", 64'(nacc), 64'd3);
            if (nacc == 3) begin
                chk("b2b_gap01", 64'(acc_cyc[1] - acc_cyc[0]), 64'(WD + 2));
                chk("b2b_gap12", 64'(acc_cyc[2] - acc_cyc[1]), 64'(WD + 2));
            end
        end

        // Single-word build.
        @(posedge clk); #1;
        chk("w1_in_ready", 64'(u1_in_ready), 64'd1);
        u1_a = 16'h8000; u1_b = 16'h8000; u1_in_valid = 1'b1;
        @(posedge clk); #1;
        u1_in_valid = 1'b0;
        chk("w1_ov_at_accept", 64'(u1_out_valid), 64'd0);
        @(posedge clk); #1;
        chk("w1_ov_latency", 64'(u1_out_valid), 64'd1);
        chk("w1_sum", 64'(u1_sum), 64'h0001);
        chk("w1_co", 64'(u1_carryout), 64'd1);
        u1_out_ready = 1'b1;
        @(posedge clk); #1;
        u1_out_ready = 1'b0;
        chk("w1_idle", 64'(u1_in_ready), 64'd1);
        chk("w1_busy", 64'(u1_busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/multiword_add_sequencer.md
# multiword_add_sequencer

Multi-cycle sequencer that adds or subtracts wide operands (NUMBITS×WORDS bits) using one shared NUMBITS-wide ripple_carry_adder. It processes one word per cycle, least-significant first, and chains the carry through a register. Operands arrive on a valid/ready input handshake; results leave on a valid/ready output handshake. It sits between an operand source (register file or host interface) and any consumer that needs wide sums without paying for a full-width carry chain.

## Interface
- NUMBITS, 16, width of the shared adder and of one word
- WORDS, 4, number of words per operand; W = NUMBITS*WORDS; WORDS ≥ 1
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operand source has a request
- in_ready  output  1  block accepts a request (high only in IDLE)
- a  input  W  operand A, sampled at the accept edge
- b  input  W  operand B, sampled at the accept edge
- carryin  input  1  initial carry for add; ignored when sub=1
- sub  input  1  0: A+B+carryin; 1: A−B (computed as A+~B+1)
- out_valid  output  1  result is available
- out_ready  input  1  consumer takes the result
- sum  output  W  result
- carryout  output  1  final carry; for sub, 1 = no borrow (A ≥ B unsigned)
- busy  output  1  high in RUN or DONE

## Operation
- States:
  - IDLE: in_ready=1. When in_valid=1, capture a, b, and sub; set carry_reg = sub ? 1 : carryin; set idx=0; go to RUN.
  - RUN: the adder receives a_reg[idx], b_reg[idx] (bitwise-inverted if sub), and carry_reg. On the edge, write sum word idx and load carry_reg from the adder carryout. If idx == WORDS−1, latch carryout and go to DONE; otherwise idx++.
  - DONE: out_valid=1. When out_ready=1, go to IDLE.
- Handshakes: a transfer happens when valid and ready are both high at a rising edge.
  - in_ready is combinational from state only. It never depends on in_valid.
  - out_valid does not depend on out_ready.
- Width and index rules:
  - All arithmetic is modulo 2^W; the overflow bit appears only on carryout.
  - idx width is max(1, $clog2(WORDS)).
- Reset, asynchronous, in any state:
  - state=IDLE, idx=0, carry_reg=0.
  - sum=0, carryout=0, out_valid=0, busy=0, in_ready=1 once reset is released.
  - An operation in progress is aborted and no result is emitted.
- Stability: sum and carryout are unchanged throughout DONE, however long out_ready stays low. in_valid is ignored outside IDLE.
- WORDS=1: exactly one RUN cycle.

## Timing
- Accept at edge T. RUN occupies edges T+1 through T+WORDS. out_valid is high from edge T+WORDS.
- Latency: WORDS cycles from accept to out_valid.
- With out_ready held high, the output transfer happens at edge T+WORDS+1. The earliest next accept is edge T+WORDS+2.
- Peak throughput is one operation per WORDS+2 cycles.
- Adder critical path: one NUMBITS ripple chain plus the operand word mux and the optional inversion.

## Structure
- Shared package: state encoding constants (IDLE, RUN, DONE) and the default NUMBITS/WORDS values.
- One sub-module: ripple_carry_adder #(NUMBITS), instantiated once.
- All sequencing, word muxing, inversion, and result registers live in multiword_add_sequencer.

## Test plan
All cases use NUMBITS=16, WORDS=4 unless stated.
- Full carry ripple: a=0xFFFF_FFFF_FFFF_FFFF, b=1, carryin=0, sub=0 → sum=0, carryout=1, out_valid exactly 4 cycles after accept.
- Borrow across words: a=0x0000_0000_0001_0000, b=1, sub=1 → sum=0x0000_0000_0000_FFFF, carryout=1. Then a=0, b=1, sub=1 → sum=0xFFFF_FFFF_FFFF_FFFF, carryout=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands → sum and carryout stable, in_ready=0, no new capture. Release → transfer, IDLE, then the new request is accepted.
- Reset mid-operation: assert rst_n=0 after 2 RUN cycles → out_valid=0, busy=0, sum=0 immediately. After release, a=5, b=7, carryin=1 → sum=13, carryout=0.
- Back-to-back: 3 requests with out_ready=1 and in_valid=1 held continuously → accepts spaced exactly WORDS+2=6 cycles apart, results in order.
- WORDS=1 build: a=0x8000, b=0x8000, carryin=1 → sum=0x0001, carryout=1, out_valid 1 cycle after accept.
